// File: rtl/peak_dpu_ls_pkg.sv
// Shared definitions for the load/store unit.
//   - ls op encodings (LB..SW) as produced by the ld/st decoder
//   - exception cause codes returned with ls_done/ls_exc
//   - FSM state encoding
//   - helpers: store detection and alignment check
package peak_dpu_ls_pkg;

    localparam logic [2:0] LS_LB  = 3'd0;
    localparam logic [2:0] LS_LH  = 3'd1;
    localparam logic [2:0] LS_LW  = 3'd2;
    localparam logic [2:0] LS_LBU = 3'd3;
    localparam logic [2:0] LS_LHU = 3'd4;
    localparam logic [2:0] LS_SB  = 3'd5;
    localparam logic [2:0] LS_SH  = 3'd6;
    localparam logic [2:0] LS_SW  = 3'd7;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_RSP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } lsu_state_t;

    function automatic logic is_store(input logic [2:0] op);
        return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] ea_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            LS_LH, LS_LHU, LS_SH: mis = ea_lo[0];
            LS_LW, LS_SW:         mis = |ea_lo;
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/peak_dpu_lsu_fmt.sv
// Lane formatting for the load/store unit (purely combinational).
//   op       : captured ls op
//   ea_lo    : low two bits of the effective address
//   st_src   : captured rs2 value
//   rdata    : raw bus read data
//   be       : byte enables (all ones for loads)
//   st_data  : lane-replicated store data
//   we       : 1 for stores
//   ld_data  : extracted and extended load result
module peak_dpu_lsu_fmt
    import peak_dpu_ls_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] st_src,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic        we,
    output logic [31:0] ld_data
);

    logic [31:0] sh;

    always_comb begin
        be      = 4'b1111;
        st_data = st_src;
        we      = 1'b0;
        sh      = rdata >> {ea_lo, 3'b000};
        ld_data = rdata;
        case (op)
            LS_LB:  ld_data = {{24{sh[7]}}, sh[7:0]};
            LS_LBU: ld_data = {24'h0, sh[7:0]};
            LS_LH:  ld_data = {{16{sh[15]}}, sh[15:0]};
            LS_LHU: ld_data = {16'h0, sh[15:0]};
            LS_LW:  ld_data = rdata;
            LS_SB: begin
                we      = 1'b1;
                be      = 4'b0001 << ea_lo;
                st_data = {4{st_src[7:0]}};
            end
            LS_SH: begin
                we      = 1'b1;
                be      = ea_lo[1] ? 4'b1100 : 4'b0011;
                st_data = {2{st_src[15:0]}};
            end
            LS_SW: begin
                we      = 1'b1;
                be      = 4'b1111;
                st_data = st_src;
            end
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/peak_dpu_lsu.sv
// Load/store execution unit. Accepts one ls op at a time, checks alignment,
// runs a single-outstanding valid/ready bus transaction and reports
// writeback plus completion/exception status.
//   ls_*       : op request from the decoder, ls_flush kills the op in flight
//   dbus_*     : data bus request (vld/rdy) and response (vld/data/err)
//   wb_*       : one-cycle load writeback
//   ls_done    : one-cycle completion, ls_exc/ls_exc_cause/ls_badaddr qualify it
//
// state | meaning
// IDLE  | ready for a new op
// REQ   | bus request presented, waiting for dbus_req_rdy
// RSP   | request accepted, waiting for response or timeout
// DRAIN | op flushed, swallowing the outstanding response
// FIN   | report completion for one cycle
module peak_dpu_lsu
    import peak_dpu_ls_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_req_vld,
    output logic        ls_req_rdy,
    input  logic [2:0]  ls_op,
    input  logic [31:0] ls_base,
    input  logic [31:0] ls_imm,
    input  logic [31:0] ls_wdata,
    input  logic [4:0]  ls_rd,
    input  logic        ls_flush,
    output logic        dbus_req_vld,
    input  logic        dbus_req_rdy,
    output logic [31:0] dbus_addr,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_rsp_vld,
    input  logic [31:0] dbus_rsp_data,
    input  logic        dbus_rsp_err,
    output logic        wb_vld,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        ls_done,
    output logic        ls_exc,
    output logic [3:0]  ls_exc_cause,
    output logic [31:0] ls_badaddr
);

    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    lsu_state_t        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       ea_q, ea_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ldata_q, ldata_d;
    logic              exc_q, exc_d;
    logic [3:0]        cause_q, cause_d;

    logic [31:0] ea;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_st_data;
    logic        fmt_we;
    logic [31:0] fmt_ld_data;
    logic        timeout_hit;
    logic [3:0]  fault_cause;
    logic        fin_live;

    assign ea = ls_base + ls_imm;

    peak_dpu_lsu_fmt u_fmt (
        .op      (op_q),
        .ea_lo   (ea_q[1:0]),
        .st_src  (wdata_q),
        .rdata   (dbus_rsp_data),
        .be      (fmt_be),
        .st_data (fmt_st_data),
        .we      (fmt_we),
        .ld_data (fmt_ld_data)
    );

    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);
    assign fault_cause = is_store(op_q) ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ea_d    = ea_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        ldata_d = ldata_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (ls_req_vld && !ls_flush) begin
                    op_d    = ls_op;
                    ea_d    = ea;
                    wdata_d = ls_wdata;
                    rd_d    = ls_rd;
                    exc_d   = 1'b0;
                    cause_d = 4'd0;
                    if (is_misaligned(ls_op, ea[1:0])) begin
                        exc_d   = 1'b1;
                        cause_d = is_store(ls_op) ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dbus_req_rdy) begin
                    cnt_d   = '0;
                    // flush on the accept cycle still owes us a response
                    state_d = ls_flush ? ST_DRAIN : ST_RSP;
                end else if (ls_flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RSP: begin
                if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // response takes priority over a coincident timeout
                if (dbus_rsp_vld) begin
                    ldata_d = fmt_ld_data;
                    if (dbus_rsp_err) begin
                        exc_d   = 1'b1;
                        cause_d = fault_cause;
                    end
                    state_d = ls_flush ? ST_IDLE : ST_FIN;
                end else if (timeout_hit) begin
                    exc_d   = 1'b1;
                    cause_d = fault_cause;
                    state_d = ls_flush ? ST_IDLE : ST_FIN;
                end else if (ls_flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (dbus_rsp_vld || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            ea_q    <= 32'h0;
            wdata_q <= 32'h0;
            rd_q    <= 5'd0;
            cnt_q   <= '0;
            ldata_q <= 32'h0;
            exc_q   <= 1'b0;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ea_q    <= ea_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ldata_q <= ldata_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
        end
    end

    // Bus fields come only from captured registers, gated by the REQ state.
    assign ls_req_rdy   = (state_q == ST_IDLE);
    assign dbus_req_vld = (state_q == ST_REQ);
    assign dbus_addr    = dbus_req_vld ? {ea_q[31:2], 2'b00} : 32'h0;
    assign dbus_we      = dbus_req_vld & fmt_we;
    assign dbus_be      = dbus_req_vld ? fmt_be : 4'b0000;
    assign dbus_wdata   = dbus_req_vld ? fmt_st_data : 32'h0;

    assign fin_live     = (state_q == ST_FIN) && !ls_flush;
    assign ls_done      = fin_live;
    assign ls_exc       = fin_live & exc_q;
    assign ls_exc_cause = ls_exc ? cause_q : 4'd0;
    assign ls_badaddr   = ls_exc ? ea_q : 32'h0;
    assign wb_vld       = fin_live & !exc_q & !is_store(op_q) & (rd_q != 5'd0);
    assign wb_addr      = wb_vld ? rd_q : 5'd0;
    assign wb_data      = wb_vld ? ldata_q : 32'h0;

endmodule

// File: tb/tb_peak_dpu_lsu.sv
// Directed bench for peak_dpu_lsu (TIMEOUT=4). Each op is accepted, then a
// fixed window of cycles is observed while a small scripted bus responds.
module tb_peak_dpu_lsu;
    import peak_dpu_ls_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ls_req_vld;
    logic        ls_req_rdy;
    logic [2:0]  ls_op;
    logic [31:0] ls_base;
    logic [31:0] ls_imm;
    logic [31:0] ls_wdata;
    logic [4:0]  ls_rd;
    logic        ls_flush;
    logic        dbus_req_vld;
    logic        dbus_req_rdy;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_rsp_vld;
    logic [31:0] dbus_rsp_data;
    logic        dbus_rsp_err;
    logic        wb_vld;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ls_done;
    logic        ls_exc;
    logic [3:0]  ls_exc_cause;
    logic [31:0] ls_badaddr;

    peak_dpu_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ls_req_vld    (ls_req_vld),
        .ls_req_rdy    (ls_req_rdy),
        .ls_op         (ls_op),
        .ls_base       (ls_base),
        .ls_imm        (ls_imm),
        .ls_wdata      (ls_wdata),
        .ls_rd         (ls_rd),
        .ls_flush      (ls_flush),
        .dbus_req_vld  (dbus_req_vld),
        .dbus_req_rdy  (dbus_req_rdy),
        .dbus_addr     (dbus_addr),
        .dbus_we       (dbus_we),
        .dbus_be       (dbus_be),
        .dbus_wdata    (dbus_wdata),
        .dbus_rsp_vld  (dbus_rsp_vld),
        .dbus_rsp_data (dbus_rsp_data),
        .dbus_rsp_err  (dbus_rsp_err),
        .wb_vld        (wb_vld),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .ls_done       (ls_done),
        .ls_exc        (ls_exc),
        .ls_exc_cause  (ls_exc_cause),
        .ls_badaddr    (ls_badaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          req_cyc, hs_cyc, done_cyc, rdy_back, done_cnt, wb_cnt;
    logic [31:0] o_addr, o_wd, o_wbdata, o_bad;
    logic [3:0]  o_be, o_cause;
    logic        o_we, o_exc, o_stable;
    logic [4:0]  o_wbaddr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        ls_req_vld    = 1'b0;
        dbus_req_rdy  = 1'b0;
        dbus_rsp_vld  = 1'b0;
        dbus_rsp_err  = 1'b0;
        dbus_rsp_data = 32'h0;
        ls_flush      = 1'b0;
    endtask

    // rsp_wait < 0: the bus never answers.
    task automatic do_op(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] wd, input logic [4:0] rd, input int rdy_wait,
                         input int rsp_wait, input logic [31:0] rdata, input logic err,
                         input bit flush_rsp);
        req_cyc = 0; hs_cyc = 0; done_cyc = 0; rdy_back = 0; done_cnt = 0; wb_cnt = 0;
        o_addr = '0; o_wd = '0; o_wbdata = '0; o_bad = '0; o_be = '0; o_cause = '0;
        o_we = 1'b0; o_exc = 1'b0; o_stable = 1'b1; o_wbaddr = '0;
        @(negedge clk);
        drive_idle();
        ls_req_vld = 1'b1;
        ls_op      = op;
        ls_base    = base;
        ls_imm     = imm;
        ls_wdata   = wd;
        ls_rd      = rd;
        #1;
        chk("accept_rdy", {31'h0, ls_req_rdy}, 32'h1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            drive_idle();
            if (hs_cyc > 0 && rsp_wait >= 0 && k == hs_cyc + 1 + rsp_wait) begin
                dbus_rsp_vld  = 1'b1;
                dbus_rsp_data = rdata;
                dbus_rsp_err  = err;
            end
            if (flush_rsp && hs_cyc > 0 && k == hs_cyc + 1) ls_flush = 1'b1;
            #1;
            if (ls_req_rdy && rdy_back == 0) rdy_back = k;
            if (dbus_req_vld) begin
                if (req_cyc == 0) begin
                    o_addr = dbus_addr; o_be = dbus_be; o_we = dbus_we; o_wd = dbus_wdata;
                end else if (o_addr !== dbus_addr || o_be !== dbus_be ||
                             o_we !== dbus_we || o_wd !== dbus_wdata) begin
                    o_stable = 1'b0;
                end
                req_cyc++;
                if (req_cyc > rdy_wait) begin
                    dbus_req_rdy = 1'b1;
                    hs_cyc = k;
                end
            end
            if (ls_done) begin
                done_cnt++;
                done_cyc = k;
                o_exc    = ls_exc;
                o_cause  = ls_exc_cause;
                o_bad    = ls_badaddr;
            end
            if (wb_vld) begin
                wb_cnt++;
                o_wbdata = wb_data;
                o_wbaddr = wb_addr;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ls_op = 3'd0; ls_base = '0; ls_imm = '0; ls_wdata = '0; ls_rd = '0;
        drive_idle();
        repeat (2) @(negedge clk);
        chk("rst_rdy",    {31'h0, ls_req_rdy},   32'h1);
        chk("rst_req",    {31'h0, dbus_req_vld}, 32'h0);
        chk("rst_done",   {31'h0, ls_done},      32'h0);
        chk("rst_wb",     {31'h0, wb_vld},       32'h0);
        chk("rst_be",     {28'h0, dbus_be},      32'h0);
        chk("rst_addr",   dbus_addr,             32'h0);
        rst_n = 1'b1;

        // LW aligned, zero-wait bus
        do_op(LS_LW, 32'h1000, 32'h4, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("lw_addr",    o_addr,                32'h1004);
        chk("lw_be",      {28'h0, o_be},         32'hF);
        chk("lw_we",      {31'h0, o_we},         32'h0);
        chk("lw_done_cyc", done_cyc,             32'd3);
        chk("lw_wb_cnt",  wb_cnt,                32'd1);
        chk("lw_wb_data", o_wbdata,              32'hDEADBEEF);
        chk("lw_wb_addr", {27'h0, o_wbaddr},     32'd5);
        chk("lw_exc",     {31'h0, o_exc},        32'h0);
        chk("lw_rdy_back", rdy_back,             32'd4);

        do_op(LS_LB, 32'h2000, 32'h3, 32'h0, 5'd1, 0, 0, 32'h80FF0000, 1'b0, 1'b0);
        chk("lb_addr",    o_addr,                32'h2000);
        chk("lb_data",    o_wbdata,              32'hFFFFFF80);
        do_op(LS_LBU, 32'h2000, 32'h3, 32'h0, 5'd2, 0, 0, 32'h80FF0000, 1'b0, 1'b0);
        chk("lbu_data",   o_wbdata,              32'h00000080);
        do_op(LS_LH, 32'h2000, 32'h2, 32'h0, 5'd3, 0, 0, 32'h80FF0000, 1'b0, 1'b0);
        chk("lh_data",    o_wbdata,              32'hFFFF80FF);
        do_op(LS_LHU, 32'h2000, 32'h0, 32'h0, 5'd3, 0, 0, 32'h1234F00D, 1'b0, 1'b0);
        chk("lhu_data",   o_wbdata,              32'h0000F00D);

        // SB lane placement
        do_op(LS_SB, 32'h3000, 32'h1, 32'h12345678, 5'd9, 0, 0, 32'h0, 1'b0, 1'b0);
        chk("sb_be",      {28'h0, o_be},         32'h2);
        chk("sb_wdata",   o_wd,                  32'h78787878);
        chk("sb_we",      {31'h0, o_we},         32'h1);
        chk("sb_done",    done_cnt,              32'd1);
        chk("sb_no_wb",   wb_cnt,                32'd0);

        // SH with negative offset, upper half
        do_op(LS_SH, 32'h3006, 32'hFFFFFFFC, 32'hAAAA5678, 5'd0, 0, 0, 32'h0, 1'b0, 1'b0);
        chk("sh_addr",    o_addr,                32'h3000);
        chk("sh_be",      {28'h0, o_be},         32'hC);
        chk("sh_wdata",   o_wd,                  32'h56785678);

        // misaligned store and load
        do_op(LS_SW, 32'h4000, 32'h2, 32'h0, 5'd0, 0, 0, 32'h0, 1'b0, 1'b0);
        chk("sw_mis_noreq", req_cyc,             32'd0);
        chk("sw_mis_cyc", done_cyc,              32'd1);
        chk("sw_mis_exc", {31'h0, o_exc},        32'h1);
        chk("sw_mis_cause", {28'h0, o_cause},    32'd6);
        chk("sw_mis_bad", o_bad,                 32'h4002);
        do_op(LS_LH, 32'h0, 32'h1, 32'h0, 5'd4, 0, 0, 32'h0, 1'b0, 1'b0);
        chk("lh_mis_cause", {28'h0, o_cause},    32'd4);
        chk("lh_mis_nowb", wb_cnt,               32'd0);
        chk("lh_mis_rdy", rdy_back,              32'd2);

        // back-pressure then bus error
        do_op(LS_LW, 32'h5000, 32'h10, 32'h0, 5'd6, 5, 0, 32'h11111111, 1'b1, 1'b0);
        chk("bp_req_cyc", req_cyc,               32'd6);
        chk("bp_stable",  {31'h0, o_stable},     32'h1);
        chk("bp_addr",    o_addr,                32'h5010);
        chk("bp_done_cyc", done_cyc,             32'd8);
        chk("bp_cause",   {28'h0, o_cause},      32'd5);
        chk("bp_bad",     o_bad,                 32'h5010);
        chk("bp_nowb",    wb_cnt,                32'd0);

        // no response: timeout after 4 RSP cycles
        do_op(LS_LW, 32'h6000, 32'h0, 32'h0, 5'd7, 0, -1, 32'h0, 1'b0, 1'b0);
        chk("to_done_cyc", done_cyc,             32'd6);
        chk("to_exc",     {31'h0, o_exc},        32'h1);
        chk("to_cause",   {28'h0, o_cause},      32'd5);
        chk("to_nowb",    wb_cnt,                32'd0);

        // store bus error
        do_op(LS_SW, 32'h6000, 32'h8, 32'hCAFEF00D, 5'd0, 0, 0, 32'h0, 1'b1, 1'b0);
        chk("swerr_cause", {28'h0, o_cause},     32'd7);

        // flush in RSP, response lands in DRAIN
        do_op(LS_LW, 32'h7000, 32'h0, 32'h0, 5'd8, 0, 1, 32'h55555555, 1'b0, 1'b1);
        chk("fl_nodone",  done_cnt,              32'd0);
        chk("fl_nowb",    wb_cnt,                32'd0);
        chk("fl_rdy_back", rdy_back,             32'd4);

        // rd=0 load completes without writeback
        do_op(LS_LW, 32'h8000, 32'h0, 32'h0, 5'd0, 0, 0, 32'h12345678, 1'b0, 1'b0);
        chk("rd0_done",   done_cnt,              32'd1);
        chk("rd0_nowb",   wb_cnt,                32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
